// File: rtl/spi_master_req_sched_pkg.sv
// Shared types for the SPI request scheduler: transfer kinds, FSM states,
// the latched request descriptor and the beat-count helper.
package spi_master_pkg;

  typedef enum logic [1:0] {
    SPI_RD  = 2'd0,
    SPI_WR  = 2'd1,
    SPI_QRD = 2'd2,
    SPI_QWR = 2'd3
  } spi_kind_e;

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    IDLE  = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    XFER  = 3'd4,
    DRAIN = 3'd5
  } sched_state_e;

  typedef struct packed {
    spi_kind_e   kind;
    logic [31:0] cmd;
    logic [31:0] addr;
    logic [5:0]  cmd_len;
    logic [5:0]  addr_len;
    logic [15:0] data_len;
    logic [15:0] dummy;
    logic [3:0]  csreg;
  } spi_req_t;

  localparam int STATUS_IDLE_BIT = 0;

  // 16'hFFFF bits rounds up to 2048 words, so 12 bits are needed
  localparam int WORD_CNT_W = 12;

  // 32-bit words needed to carry data_len bits; the sum is done in 17 bits
  function automatic logic [WORD_CNT_W-1:0] data_words(input logic [15:0] data_len);
    logic [16:0] sum;
    sum = {1'b0, data_len} + 17'd31;
    return sum[16:5];
  endfunction

  function automatic logic is_write(input spi_kind_e kind);
    return (kind == SPI_WR) || (kind == SPI_QWR);
  endfunction

endpackage

// File: rtl/spi_master_req_sched_if.sv
// Requester-side and core-side bundles of the SPI request scheduler.
// The scheduler uses req.slave and core.master.
interface spi_req_if #(parameter int N_REQ = 2);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0][1:0]   req_kind;
  logic [N_REQ-1:0][31:0]  req_cmd;
  logic [N_REQ-1:0][31:0]  req_addr;
  logic [N_REQ-1:0][5:0]   req_cmd_len;
  logic [N_REQ-1:0][5:0]   req_addr_len;
  logic [N_REQ-1:0][15:0]  req_data_len;
  logic [N_REQ-1:0][15:0]  req_dummy;
  logic [N_REQ-1:0][3:0]   req_csreg;
  logic [N_REQ-1:0][31:0]  tx_data;
  logic [N_REQ-1:0]        tx_valid;
  logic [N_REQ-1:0]        tx_ready;
  logic [31:0]             rx_data;
  logic [N_REQ-1:0]        rx_valid;
  logic [N_REQ-1:0]        rx_ready;
  logic [N_REQ-1:0]        done;

  modport master (
    output req_valid, req_kind, req_cmd, req_addr, req_cmd_len, req_addr_len,
           req_data_len, req_dummy, req_csreg, tx_data, tx_valid, rx_ready,
    input  req_ready, tx_ready, rx_data, rx_valid, done
  );

  modport slave (
    input  req_valid, req_kind, req_cmd, req_addr, req_cmd_len, req_addr_len,
           req_data_len, req_dummy, req_csreg, tx_data, tx_valid, rx_ready,
    output req_ready, tx_ready, rx_data, rx_valid, done
  );
endinterface

interface spi_core_if;
  logic [31:0] spi_status;
  logic [7:0]  spi_clk_div;
  logic        spi_clk_div_valid;
  logic [31:0] spi_cmd;
  logic [31:0] spi_addr;
  logic [5:0]  spi_cmd_len;
  logic [5:0]  spi_addr_len;
  logic [15:0] spi_data_len;
  logic [15:0] spi_dummy_rd;
  logic [15:0] spi_dummy_wr;
  logic [3:0]  spi_csreg;
  logic        spi_rd;
  logic        spi_wr;
  logic        spi_qrd;
  logic        spi_qwr;
  logic        spi_swrst;
  logic [31:0] spi_data_tx;
  logic        spi_data_tx_valid;
  logic        spi_data_tx_ready;
  logic [31:0] spi_data_rx;
  logic        spi_data_rx_valid;
  logic        spi_data_rx_ready;

  modport master (
    input  spi_status, spi_data_tx_ready, spi_data_rx, spi_data_rx_valid,
    output spi_clk_div, spi_clk_div_valid, spi_cmd, spi_addr, spi_cmd_len,
           spi_addr_len, spi_data_len, spi_dummy_rd, spi_dummy_wr, spi_csreg,
           spi_rd, spi_wr, spi_qrd, spi_qwr, spi_swrst,
           spi_data_tx, spi_data_tx_valid, spi_data_rx_ready
  );

  modport slave (
    output spi_status, spi_data_tx_ready, spi_data_rx, spi_data_rx_valid,
    input  spi_clk_div, spi_clk_div_valid, spi_cmd, spi_addr, spi_cmd_len,
           spi_addr_len, spi_data_len, spi_dummy_rd, spi_dummy_wr, spi_csreg,
           spi_rd, spi_wr, spi_qrd, spi_qwr, spi_swrst,
           spi_data_tx, spi_data_tx_valid, spi_data_rx_ready
  );
endinterface

// File: rtl/spi_master_req_sched_arbiter.sv
// Round-robin arbiter: grants the first pending request at or after ptr,
// wrapping around N_REQ. Purely combinational.
module spi_rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  input  logic             enable,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    idx,
  output logic             any
);

  // scan from the pointer, wrapping, and take the first pending request
  always_comb begin
    int cand;
    cand  = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (enable && !any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/spi_master_req_sched.sv
// Schedules whole SPI transactions from N_REQ requesters onto one SPI master
// core: round-robin grant, config load, single start strobe, FIFO routing to
// the owner, then a done pulse once the core reports idle.
module spi_master_req_sched
  import spi_master_pkg::*;
#(
  parameter int          N_REQ      = 2,
  parameter logic [7:0]  CLKDIV_RST = 8'h00
) (
  input logic        HCLK,
  input logic        HRESETn,
  spi_req_if.slave   req,
  spi_core_if.master core
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  sched_state_e          state, state_n;
  spi_req_t              cfg;
  logic [IW-1:0]         rr_ptr, owner, gnt_idx;
  logic [N_REQ-1:0]      gnt, owner_oh;
  logic                  gnt_any, arb_en, take, beat;
  logic [WORD_CNT_W-1:0] words_left;
  logic                  core_idle, owner_wr;
  logic                  swrst_q, div_valid_q;

  assign core_idle = core.spi_status[STATUS_IDLE_BIT];
  assign owner_wr  = is_write(cfg.kind);
  assign arb_en    = (state == IDLE) && core_idle;

  spi_rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_arb (
    .req    (req.req_valid),
    .ptr    (rr_ptr),
    .enable (arb_en),
    .grant  (gnt),
    .idx    (gnt_idx),
    .any    (gnt_any)
  );

  // latched request is presented to the core unchanged until the next grant
  assign core.spi_cmd           = cfg.cmd;
  assign core.spi_addr          = cfg.addr;
  assign core.spi_cmd_len       = cfg.cmd_len;
  assign core.spi_addr_len      = cfg.addr_len;
  assign core.spi_data_len      = cfg.data_len;
  assign core.spi_dummy_rd      = cfg.dummy;
  assign core.spi_dummy_wr      = cfg.dummy;
  assign core.spi_csreg         = cfg.csreg;
  assign core.spi_clk_div       = CLKDIV_RST;
  assign core.spi_clk_div_valid = div_valid_q;
  assign core.spi_swrst         = swrst_q;

  // state register
  always_ff @(posedge HCLK) begin
    if (!HRESETn) state <= INIT;
    else          state <= state_n;
  end

  // next state, start strobes, completion and owner-only stream routing
  always_comb begin
    state_n                = state;
    take                   = 1'b0;
    beat                   = 1'b0;
    req.req_ready          = '0;
    req.done               = '0;
    req.tx_ready           = '0;
    req.rx_valid           = '0;
    req.rx_data            = '0;
    core.spi_rd            = 1'b0;
    core.spi_wr            = 1'b0;
    core.spi_qrd           = 1'b0;
    core.spi_qwr           = 1'b0;
    core.spi_data_tx       = '0;
    core.spi_data_tx_valid = 1'b0;
    core.spi_data_rx_ready = 1'b0;
    unique case (state)
      INIT: state_n = IDLE;
      IDLE: begin
        if (gnt_any) begin
          take          = 1'b1;
          req.req_ready = gnt;
          state_n       = LOAD;
        end
      end
      LOAD: state_n = START;
      START: begin
        case (cfg.kind)
          SPI_RD:  core.spi_rd  = 1'b1;
          SPI_WR:  core.spi_wr  = 1'b1;
          SPI_QRD: core.spi_qrd = 1'b1;
          SPI_QWR: core.spi_qwr = 1'b1;
          default: ;
        endcase
        state_n = (data_words(cfg.data_len) == '0) ? DRAIN : XFER;
      end
      XFER: begin
        if (owner_wr) begin
          core.spi_data_tx       = req.tx_data[owner];
          core.spi_data_tx_valid = req.tx_valid[owner];
          req.tx_ready           = owner_oh & {N_REQ{core.spi_data_tx_ready}};
          beat                   = req.tx_valid[owner] & core.spi_data_tx_ready;
        end else begin
          req.rx_data            = core.spi_data_rx;
          req.rx_valid           = owner_oh & {N_REQ{core.spi_data_rx_valid}};
          core.spi_data_rx_ready = req.rx_ready[owner];
          beat                   = core.spi_data_rx_valid & req.rx_ready[owner];
        end
        if (beat && (words_left == WORD_CNT_W'(1))) state_n = DRAIN;
      end
      DRAIN: begin
        if (core_idle) begin
          req.done = owner_oh;
          state_n  = IDLE;
        end
      end
      default: state_n = INIT;
    endcase
  end

  // grant bookkeeping, latched request fields and remaining-word counter
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      rr_ptr     <= '0;
      owner      <= '0;
      owner_oh   <= '0;
      cfg        <= '0;
      words_left <= '0;
    end else begin
      if (take) begin
        owner    <= gnt_idx;
        owner_oh <= gnt;
        rr_ptr   <= (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        cfg      <= '{kind:     spi_kind_e'(req.req_kind[gnt_idx]),
                      cmd:      req.req_cmd[gnt_idx],
                      addr:     req.req_addr[gnt_idx],
                      cmd_len:  req.req_cmd_len[gnt_idx],
                      addr_len: req.req_addr_len[gnt_idx],
                      data_len: req.req_data_len[gnt_idx],
                      dummy:    req.req_dummy[gnt_idx],
                      csreg:    req.req_csreg[gnt_idx]};
      end
      if (state == START)  words_left <= data_words(cfg.data_len);
      else if (beat)       words_left <= words_left - 1'b1;
    end
  end

  // one-shot core soft reset and divider load on leaving INIT; registered so
  // both stay low while HRESETn is held
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      swrst_q     <= 1'b0;
      div_valid_q <= 1'b0;
    end else begin
      swrst_q     <= (state == INIT);
      div_valid_q <= (state == INIT);
    end
  end

endmodule

// File: tb/tb_spi_master_req_sched.sv
// Self-checking bench for spi_master_req_sched: randomized requester and core
// behaviour checked against a transaction-level reference model.
`timescale 1ns/1ps
module tb_spi_master_req_sched;

  localparam int         N      = 2;
  localparam logic [7:0] CLKDIV = 8'h5A;

  logic HCLK    = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  spi_req_if #(.N_REQ(N)) rq ();
  spi_core_if             cr ();

  spi_master_req_sched #(.N_REQ(N), .CLKDIV_RST(CLKDIV)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .req     (rq),
    .core    (cr)
  );

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  // requester-side reference model
  logic [1:0]  t_kind [N];
  logic [31:0] t_cmd  [N];
  logic [31:0] t_addr [N];
  logic [5:0]  t_cl   [N];
  logic [5:0]  t_al   [N];
  logic [15:0] t_dl   [N];
  logic [15:0] t_dm   [N];
  logic [3:0]  t_cs   [N];
  bit          pending[N];
  int  rr = 0;
  bit  active = 0;
  int  owner_e = 0;
  int  grant_cyc = 0;
  int  strobes = 0;
  int  beats = 0;
  int  grant_log[$];

  // behavioural SPI core
  bit c_busy = 0;
  bit c_rd   = 0;
  int c_left = 0;
  int c_tail = 0;

  int swrst_cnt = 0, divv_cnt = 0, done_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] onehot(input int g);
    if (g < 0) return 64'd0;
    return 64'd1 << g;
  endfunction

  function automatic bit kind_wr(input logic [1:0] k);
    return (k == 2'd1) || (k == 2'd3);
  endfunction

  function automatic int words(input logic [15:0] dl);
    return (int'(dl) + 31) / 32;
  endfunction

  function automatic int ref_grant();
    for (int k = 0; k < N; k++)
      if (pending[(rr + k) % N]) return (rr + k) % N;
    return -1;
  endfunction

  function automatic bit any_pending();
    for (int i = 0; i < N; i++) if (pending[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive();
    logic [31:0] st;
    for (int i = 0; i < N; i++) begin
      rq.req_valid[i]    = pending[i];
      rq.req_kind[i]     = t_kind[i];
      rq.req_cmd[i]      = t_cmd[i];
      rq.req_addr[i]     = t_addr[i];
      rq.req_cmd_len[i]  = t_cl[i];
      rq.req_addr_len[i] = t_al[i];
      rq.req_data_len[i] = t_dl[i];
      rq.req_dummy[i]    = t_dm[i];
      rq.req_csreg[i]    = t_cs[i];
      rq.tx_valid[i]     = 1'($urandom_range(0, 1));
      rq.tx_data[i]      = $urandom();
      rq.rx_ready[i]     = 1'($urandom_range(0, 1));
    end
    st    = $urandom();
    st[0] = !c_busy;
    cr.spi_status        = st;
    cr.spi_data_tx_ready = c_busy && !c_rd && (c_left > 0) && ($urandom_range(0, 1) == 1);
    cr.spi_data_rx_valid = c_busy && c_rd && (c_left > 0) && ($urandom_range(0, 1) == 1);
    cr.spi_data_rx       = $urandom();
  endtask

  task automatic sample();
    logic [3:0] stb;
    bool_block: begin
      stb = {cr.spi_qwr, cr.spi_qrd, cr.spi_wr, cr.spi_rd};
      if (cr.spi_clk_div_valid) divv_cnt++;
      if (cr.spi_swrst) begin
        swrst_cnt++;
        c_busy = 0; c_left = 0; c_tail = 0;
      end
      // core model progress
      if (c_busy && c_left > 0) begin
        if (c_rd ? (cr.spi_data_rx_valid && cr.spi_data_rx_ready)
                 : (cr.spi_data_tx_valid && cr.spi_data_tx_ready)) c_left--;
      end else if (c_busy) begin
        if (c_tail > 0) c_tail--;
        else c_busy = 0;
      end
      // routing: only the owner of an active transfer may see stream handshakes
      for (int i = 0; i < N; i++) begin
        if (!(active && i == owner_e && kind_wr(t_kind[owner_e])))
          chk("tx_ready_gated", rq.tx_ready[i], 1'b0);
        if (!(active && i == owner_e && !kind_wr(t_kind[owner_e])))
          chk("rx_valid_gated", rq.rx_valid[i], 1'b0);
      end
      if (active && kind_wr(t_kind[owner_e])) begin
        if (rq.tx_valid[owner_e] && rq.tx_ready[owner_e]) begin
          beats++;
          chk("tx_data_route", cr.spi_data_tx, rq.tx_data[owner_e]);
          chk("tx_valid_route", cr.spi_data_tx_valid, 1'b1);
        end
      end else if (active) begin
        if (rq.rx_valid[owner_e] && rq.rx_ready[owner_e]) begin
          beats++;
          chk("rx_data_route", rq.rx_data, cr.spi_data_rx);
          chk("rx_ready_route", cr.spi_data_rx_ready, 1'b1);
        end
      end
      if (rq.done != '0) begin
        done_cnt++;
        chk("done_expected", active, 1'b1);
        chk("done_onehot", rq.done, onehot(owner_e));
        chk("done_core_idle", cr.spi_status[0], 1'b1);
        chk("strobe_count", strobes, 1);
        chk("beat_count", beats, words(t_dl[owner_e]));
        active = 0;
      end
      if (rq.req_ready != '0) begin
        int g, obs_g;
        g = ref_grant();
        obs_g = -1;
        for (int i = 0; i < N; i++) if (rq.req_ready[i]) obs_g = i;
        chk("grant_onehot", rq.req_ready, onehot(g));
        chk("grant_while_free", active, 1'b0);
        grant_log.push_back(obs_g);
        if (g >= 0) begin
          active = 1; owner_e = g; pending[g] = 0;
          grant_cyc = cyc_n; strobes = 0; beats = 0;
          rr = (g + 1) % N;
        end
      end
      if (stb != 4'd0) begin
        strobes++;
        chk("strobe_kind", stb, 4'd1 << t_kind[owner_e]);
        chk("strobe_delay", cyc_n - grant_cyc, 2);
        chk("cfg_cmd", cr.spi_cmd, t_cmd[owner_e]);
        chk("cfg_addr", cr.spi_addr, t_addr[owner_e]);
        chk("cfg_cmd_len", cr.spi_cmd_len, t_cl[owner_e]);
        chk("cfg_addr_len", cr.spi_addr_len, t_al[owner_e]);
        chk("cfg_data_len", cr.spi_data_len, t_dl[owner_e]);
        chk("cfg_dummy_rd", cr.spi_dummy_rd, t_dm[owner_e]);
        chk("cfg_dummy_wr", cr.spi_dummy_wr, t_dm[owner_e]);
        chk("cfg_csreg", cr.spi_csreg, t_cs[owner_e]);
        c_busy = 1;
        c_rd   = cr.spi_rd | cr.spi_qrd;
        c_left = words(cr.spi_data_len);
        c_tail = $urandom_range(1, 3);
      end
    end
  endtask

  task automatic cyc();
    @(negedge HCLK);
    drive();
    #1;
    sample();
    cyc_n++;
  endtask

  task automatic submit(input int r, input logic [1:0] k, input logic [31:0] cmd,
                        input logic [31:0] addr, input logic [5:0] cl, input logic [5:0] al,
                        input logic [15:0] dl, input logic [15:0] dm, input logic [3:0] cs);
    t_kind[r] = k; t_cmd[r] = cmd; t_addr[r] = addr; t_cl[r] = cl; t_al[r] = al;
    t_dl[r] = dl; t_dm[r] = dm; t_cs[r] = cs; pending[r] = 1;
  endtask

  task automatic run_until_quiet(input string tag, input int budget);
    int n;
    bit quiet;
    n = 0;
    while ((any_pending() || active) && n < budget) begin
      cyc();
      n++;
    end
    quiet = !(any_pending() || active);
    chk({tag, "_complete"}, quiet, 1'b1);
    if (!quiet) begin
      active = 0;
      for (int i = 0; i < N; i++) pending[i] = 0;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, rq.req_ready, '0);
    chk({tag, "_done"}, rq.done, '0);
    chk({tag, "_tx_ready"}, rq.tx_ready, '0);
    chk({tag, "_rx_valid"}, rq.rx_valid, '0);
    chk({tag, "_rx_data"}, rq.rx_data, '0);
    chk({tag, "_strobes"}, {cr.spi_rd, cr.spi_wr, cr.spi_qrd, cr.spi_qwr, cr.spi_swrst}, '0);
    chk({tag, "_div_valid"}, cr.spi_clk_div_valid, 1'b0);
    chk({tag, "_clk_div"}, cr.spi_clk_div, CLKDIV);
    chk({tag, "_cfg"}, {cr.spi_cmd, cr.spi_addr}, '0);
    chk({tag, "_lens"}, {cr.spi_cmd_len, cr.spi_addr_len, cr.spi_data_len, cr.spi_csreg}, '0);
    chk({tag, "_dummy"}, {cr.spi_dummy_rd, cr.spi_dummy_wr}, '0);
    chk({tag, "_tx_path"}, {cr.spi_data_tx, cr.spi_data_tx_valid, cr.spi_data_rx_ready}, '0);
  endtask

  initial begin
    int n, sw0, dv0, dn0;
    for (int i = 0; i < N; i++) begin
      t_kind[i] = '0; t_cmd[i] = '0; t_addr[i] = '0; t_cl[i] = '0; t_al[i] = '0;
      t_dl[i] = '0; t_dm[i] = '0; t_cs[i] = '0; pending[i] = 0;
    end
    drive();

    // reset state and the single INIT pulse pair
    HRESETn = 1'b0;
    repeat (3) cyc();
    chk_all_zero("reset");
    HRESETn = 1'b1;
    repeat (6) cyc();
    chk("init_swrst_once", swrst_cnt, 1);
    chk("init_div_valid_once", divv_cnt, 1);
    chk("post_init_strobes", {cr.spi_rd, cr.spi_wr, cr.spi_qrd, cr.spi_qwr, cr.spi_swrst}, '0);
    chk("post_init_clk_div", cr.spi_clk_div, CLKDIV);

    // quad read from requester 0: two RX words
    submit(0, 2'd2, 32'h0000_00EB, 32'h0000_1000, 6'd8, 6'd24, 16'd64, 16'd8, 4'd1);
    run_until_quiet("qrd_req0", 400);

    // write from requester 1, 33 bits -> two TX words under gapped handshakes
    submit(1, 2'd1, 32'h0000_0002, 32'h0000_2040, 6'd8, 6'd24, 16'd33, 16'd0, 4'd2);
    run_until_quiet("wr_req1", 400);

    // simultaneous requests, two rounds
    grant_log.delete();
    for (int r = 0; r < 2; r++) begin
      submit(0, 2'd0, 32'h03, 32'h100 + r, 6'd8, 6'd24, 16'd32, 16'd4, 4'd1);
      submit(1, 2'd3, 32'h32, 32'h200 + r, 6'd8, 6'd24, 16'd40, 16'd6, 4'd2);
      run_until_quiet("rr_pair", 800);
    end
    chk("rr_order_len", grant_log.size(), 4);
    if (grant_log.size() == 4) begin
      chk("rr_order_0", grant_log[0], 0);
      chk("rr_order_1", grant_log[1], 1);
      chk("rr_order_2", grant_log[2], 0);
      chk("rr_order_3", grant_log[3], 1);
    end

    // zero-length read: strobe, no data beats, done after core idle
    submit(0, 2'd0, 32'h05, 32'h0, 6'd8, 6'd0, 16'd0, 16'd0, 4'd3);
    run_until_quiet("rd_zero", 200);

    // randomized mixes
    for (int t = 0; t < 10; t++) begin
      int mask;
      mask = $urandom_range(1, 3);
      for (int i = 0; i < N; i++)
        if (mask[i])
          submit(i, 2'($urandom_range(0, 3)), $urandom(), $urandom(),
                 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
                 16'($urandom_range(0, 200)), 16'($urandom()), 4'($urandom_range(0, 15)));
      run_until_quiet("random", 1500);
    end

    // reset in the middle of a long read
    submit(1, 2'd2, 32'h6B, 32'h4000, 6'd8, 6'd24, 16'd256, 16'd8, 4'd1);
    n = 0;
    while (!(active && beats >= 2) && n < 400) begin
      cyc();
      n++;
    end
    chk("mid_xfer_reached", (active && beats >= 2), 1'b1);
    sw0 = swrst_cnt; dv0 = divv_cnt; dn0 = done_cnt;
    HRESETn = 1'b0;
    active = 0; rr = 0;
    for (int i = 0; i < N; i++) pending[i] = 0;
    cyc();
    chk_all_zero("abort");
    HRESETn = 1'b1;
    repeat (8) cyc();
    chk("abort_swrst_once", swrst_cnt - sw0, 1);
    chk("abort_div_valid_once", divv_cnt - dv0, 1);
    chk("abort_no_done", done_cnt - dn0, 0);
    grant_log.delete();
    submit(1, 2'd1, 32'h02, 32'h10, 6'd8, 6'd24, 16'd40, 16'd0, 4'd2);
    run_until_quiet("after_abort", 400);
    chk("after_abort_grants", grant_log.size(), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
